// File: rtl/mips_cpu_core_if.sv
// rtl/mips_cpu_core_if.sv - byte-wide parallel flash read bus
interface mips_cpu_core_if;
    logic [21:0] FL_ADDR;
    logic [7:0]  FL_DQ;
    logic        FL_CE_N;
    logic        FL_OE_N;
    logic        FL_WE_N;
    logic        FL_RST_N;

    modport master (
        output FL_ADDR,
        output FL_CE_N,
        output FL_OE_N,
        output FL_WE_N,
        output FL_RST_N,
        input  FL_DQ
    );

    modport slave (
        input  FL_ADDR,
        input  FL_CE_N,
        input  FL_OE_N,
        input  FL_WE_N,
        input  FL_RST_N,
        output FL_DQ
    );
endinterface

// File: rtl/mips_cpu_core.sv
// rtl/mips_cpu_core.sv - multicycle MIPS-I subset core fetching from byte-wide flash
module mips_cpu_core #(
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              CLOCK_50,
    input  logic              Global_Reset,
    mips_cpu_core_if.master   fl,
    output logic [31:0]       Dbg_Pc,
    output logic              Dbg_WrEn,
    output logic [4:0]        Dbg_WrReg,
    output logic [31:0]       Dbg_WrData,
    output logic              Halted,
    output logic              Error
);
    localparam int AW = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    fcnt;
    logic [31:0]   ir, pc, npc, npc_next, a, b;
    logic [21:0]   fl_addr;
    logic [31:0]   gpr [32];
    logic [31:0]   dmem [DMEM_WORDS];
    logic [AW-1:0] mem_idx;
    logic          lw_op, sw_op;

    // instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] simm, zimm, pc4, br_tgt, j_tgt, addr_sum;

    // execute results
    logic [31:0] res, tgt;
    logic [4:0]  wreg;
    logic        wr, is_mem, is_store, brk, ill;

    // FSM control strobes
    logic fetch_en, byte_en, decode_en, exec_en, mem_en, wb_en;

    assign fl.FL_ADDR  = fl_addr;
    assign fl.FL_CE_N  = 1'b0;
    assign fl.FL_OE_N  = 1'b0;
    assign fl.FL_WE_N  = 1'b1;
    assign fl.FL_RST_N = 1'b1;
    assign Dbg_Pc      = pc;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign simm     = {{16{imm[15]}}, imm};
    assign zimm     = {16'h0000, imm};
    assign pc4      = pc + 32'd4;
    assign br_tgt   = pc4 + {simm[29:0], 2'b00};
    assign j_tgt    = {pc4[31:28], ir[25:0], 2'b00};
    assign addr_sum = a + simm;

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (Global_Reset) state <= S_FETCH;
        else              state <= state_nxt;
    end

    // next-state logic; BREAK and illegal opcodes divert from EXEC into HALT
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (fcnt == 3'd7) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   begin
                if (brk || ill)  state_nxt = S_HALT;
                else if (is_mem) state_nxt = S_MEM;
                else             state_nxt = S_WB;
            end
            S_MEM:    state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_HALT;
        endcase
    end

    // per-state control strobes
    always_comb begin
        fetch_en  = (state == S_FETCH);
        byte_en   = (state == S_FETCH) && fcnt[0];
        decode_en = (state == S_DECODE);
        exec_en   = (state == S_EXEC);
        mem_en    = (state == S_MEM);
        wb_en     = (state == S_WB);
    end

    // instruction decode and ALU / branch-target evaluation on the latched operands
    always_comb begin
        res      = 32'h0;
        wr       = 1'b0;
        wreg     = rt;
        tgt      = npc + 32'd4;
        is_mem   = 1'b0;
        is_store = 1'b0;
        brk      = 1'b0;
        ill      = 1'b0;
        case (opcode)
            6'h00: begin
                wreg = rd;
                wr   = 1'b1;
                case (funct)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24:        res = a & b;
                    6'h25:        res = a | b;
                    6'h26:        res = a ^ b;
                    6'h27:        res = ~(a | b);
                    6'h2A:        res = {31'h0, $signed(a) < $signed(b)};
                    6'h2B:        res = {31'h0, a < b};
                    6'h00:        res = b << shamt;
                    6'h02:        res = b >> shamt;
                    6'h03:        res = $signed(b) >>> shamt;
                    6'h08:        begin wr = 1'b0; tgt = a; end
                    6'h0D:        begin wr = 1'b0; brk = 1'b1; end
                    default:      begin wr = 1'b0; ill = 1'b1; end
                endcase
            end
            6'h08, 6'h09: begin wr = 1'b1; res = addr_sum; end
            6'h0A: begin wr = 1'b1; res = {31'h0, $signed(a) < $signed(simm)}; end
            6'h0B: begin wr = 1'b1; res = {31'h0, a < simm}; end
            6'h0C: begin wr = 1'b1; res = a & zimm; end
            6'h0D: begin wr = 1'b1; res = a | zimm; end
            6'h0E: begin wr = 1'b1; res = a ^ zimm; end
            6'h0F: begin wr = 1'b1; res = {imm, 16'h0000}; end
            6'h23: is_mem = 1'b1;
            6'h2B: begin is_mem = 1'b1; is_store = 1'b1; end
            6'h04: if (a == b) tgt = br_tgt;
            6'h05: if (a != b) tgt = br_tgt;
            6'h02: tgt = j_tgt;
            6'h03: begin tgt = j_tgt; wr = 1'b1; wreg = 5'd31; res = pc + 32'd8; end
            default: ill = 1'b1;
        endcase
    end

    // datapath: fetch assembly, operand read, execute latch, memory read, write-back
    always_ff @(posedge CLOCK_50) begin
        if (Global_Reset) begin
            fcnt       <= 3'd0;
            ir         <= 32'h0;
            pc         <= RESET_PC;
            npc        <= RESET_PC + 32'd4;
            npc_next   <= 32'h0;
            a          <= 32'h0;
            b          <= 32'h0;
            fl_addr    <= RESET_PC[21:0];
            mem_idx    <= '0;
            lw_op      <= 1'b0;
            sw_op      <= 1'b0;
            Dbg_WrEn   <= 1'b0;
            Dbg_WrReg  <= 5'd0;
            Dbg_WrData <= 32'h0;
            Halted     <= 1'b0;
            Error      <= 1'b0;
            for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
        end else begin
            if (fetch_en) begin
                fcnt <= fcnt + 3'd1;
                if (byte_en) ir <= {ir[23:0], fl.FL_DQ};
                // hold the last byte address once the word is complete
                if (fcnt != 3'd7) begin
                    fl_addr <= pc[21:0] + {20'h0, fcnt[2:1] + {1'b0, fcnt[0]}};
                end
            end
            if (decode_en) begin
                a <= (rs == 5'd0) ? 32'h0 : gpr[rs];
                b <= (rt == 5'd0) ? 32'h0 : gpr[rt];
            end
            if (exec_en) begin
                npc_next <= tgt;
                mem_idx  <= addr_sum[AW+1:2];
                lw_op    <= is_mem && !is_store;
                sw_op    <= is_store;
                if (brk || ill) begin
                    Halted <= 1'b1;
                    Error  <= Error | ill;
                end else if (!is_mem && wr && wreg != 5'd0) begin
                    Dbg_WrEn   <= 1'b1;
                    Dbg_WrReg  <= wreg;
                    Dbg_WrData <= res;
                end
            end
            if (mem_en && lw_op && rt != 5'd0) begin
                Dbg_WrEn   <= 1'b1;
                Dbg_WrReg  <= rt;
                Dbg_WrData <= dmem[mem_idx];
            end
            if (wb_en) begin
                if (Dbg_WrEn) gpr[Dbg_WrReg] <= Dbg_WrData;
                Dbg_WrEn <= 1'b0;
                pc       <= npc;
                npc      <= npc_next;
                fl_addr  <= npc[21:0];
                fcnt     <= 3'd0;
            end
        end
    end

    // data RAM store port; contents survive reset
    always_ff @(posedge CLOCK_50) begin
        if (mem_en && sw_op) dmem[mem_idx] <= b;
    end
endmodule

// File: tb/tb_mips_cpu_core.sv
// tb/tb_mips_cpu_core.sv - directed self-checking bench for mips_cpu_core
module tb_mips_cpu_core;
    logic        clk;
    logic        rst;
    logic [31:0] dbg_pc;
    logic        dbg_wr_en;
    logic [4:0]  dbg_wr_reg;
    logic [31:0] dbg_wr_data;
    logic        halted;
    logic        error;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] flash [256];

    mips_cpu_core_if fl_if ();

    assign fl_if.FL_DQ = flash[fl_if.FL_ADDR[7:0]];

    mips_cpu_core dut (
        .CLOCK_50     (clk),
        .Global_Reset (rst),
        .fl           (fl_if.master),
        .Dbg_Pc       (dbg_pc),
        .Dbg_WrEn     (dbg_wr_en),
        .Dbg_WrReg    (dbg_wr_reg),
        .Dbg_WrData   (dbg_wr_data),
        .Halted       (halted),
        .Error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_flash();
        for (int i = 0; i < 256; i++) flash[i] = 8'h00;
    endtask

    task automatic put_word(input int addr, input logic [31:0] w);
        flash[addr]     = w[31:24];
        flash[addr + 1] = w[23:16];
        flash[addr + 2] = w[15:8];
        flash[addr + 3] = w[7:0];
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input logic [4:0] r, input logic [31:0] d,
                           input logic [31:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!dbg_wr_en && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_en"},   {31'h0, dbg_wr_en}, 32'd1);
        chk({tag, "_reg"},  {27'h0, dbg_wr_reg}, {27'h0, r});
        chk({tag, "_data"}, dbg_wr_data, d);
        chk({tag, "_pc"},   dbg_pc, pc);
    endtask

    task automatic wait_halt();
        int n;
        n = 0;
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fladdr"}, {10'h0, fl_if.FL_ADDR}, 32'h0);
        chk({tag, "_pc"},     dbg_pc, 32'h0);
        chk({tag, "_wren"},   {31'h0, dbg_wr_en}, 32'h0);
        chk({tag, "_wrreg"},  {27'h0, dbg_wr_reg}, 32'h0);
        chk({tag, "_wrdata"}, dbg_wr_data, 32'h0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'h0);
        chk({tag, "_error"},  {31'h0, error}, 32'h0);
    endtask

    initial begin
        int bad;
        rst = 1'b1;

        // 1: LUI r1,0x1234; flash address walk and WB in cycle 11
        clear_flash();
        put_word(0, 32'h3C01_1234);
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("t1_rst");
        chk("t1_ce_n",  {31'h0, fl_if.FL_CE_N},  32'd0);
        chk("t1_oe_n",  {31'h0, fl_if.FL_OE_N},  32'd0);
        chk("t1_we_n",  {31'h0, fl_if.FL_WE_N},  32'd1);
        chk("t1_rst_n", {31'h0, fl_if.FL_RST_N}, 32'd1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_addr_c%0d", k + 1), {10'h0, fl_if.FL_ADDR}, k >> 1);
            chk($sformatf("t1_noen_c%0d", k + 1), {31'h0, dbg_wr_en}, 32'd0);
            @(negedge clk);
        end
        chk("t1_noen_c9", {31'h0, dbg_wr_en}, 32'd0);
        @(negedge clk);
        chk("t1_noen_c10", {31'h0, dbg_wr_en}, 32'd0);
        @(negedge clk);
        chk("t1_en_c11", {31'h0, dbg_wr_en}, 32'd1);
        chk("t1_reg",    {27'h0, dbg_wr_reg}, 32'd1);
        chk("t1_data",   dbg_wr_data, 32'h1234_0000);
        chk("t1_pc",     dbg_pc, 32'h0);

        // 2: ADDIU r2,r0,-1; SLTU r3,r0,r2; SLT r4,r0,r2
        clear_flash();
        put_word(0, 32'h2402_FFFF);
        put_word(4, 32'h0002_182B);
        put_word(8, 32'h0002_202A);
        restart();
        wait_wr("t2_addiu", 5'd2, 32'hFFFF_FFFF, 32'h0);
        wait_wr("t2_sltu",  5'd3, 32'h1,         32'h4);
        wait_wr("t2_slt",   5'd4, 32'h0,         32'h8);

        // 3: ADDIU r3,r0,0x55; SW r3,16(r0); LW r4,16(r0)
        clear_flash();
        put_word(0, 32'h2403_0055);
        put_word(4, 32'hAC03_0010);
        put_word(8, 32'h8C04_0010);
        restart();
        wait_wr("t3_addiu", 5'd3, 32'h55, 32'h0);
        bad = 0;
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (dbg_wr_en !== 1'b0) bad++;
        end
        chk("t3_sw_no_wren", bad, 32'd0);
        @(negedge clk);
        chk("t3_lw_en",   {31'h0, dbg_wr_en}, 32'd1);
        chk("t3_lw_reg",  {27'h0, dbg_wr_reg}, 32'd4);
        chk("t3_lw_data", dbg_wr_data, 32'h55);
        chk("t3_lw_pc",   dbg_pc, 32'h8);

        // 4: taken BNE with delay slot and skipped instruction
        clear_flash();
        put_word(0,  32'h2402_0001);
        put_word(4,  32'h1440_0002);
        put_word(8,  32'h3405_0005);
        put_word(12, 32'h3406_0006);
        put_word(16, 32'h3407_0007);
        restart();
        wait_wr("t4_r2",     5'd2, 32'h1, 32'h0);
        wait_wr("t4_slot",   5'd5, 32'h5, 32'h8);
        wait_wr("t4_target", 5'd7, 32'h7, 32'h10);

        // 5: J 0x20; JAL 0x40 at 0x20; JR r31 at 0x40
        clear_flash();
        put_word(0,    32'h0800_0008);
        put_word(32,   32'h0C00_0010);
        put_word(36,   32'h340A_000A);
        put_word(40,   32'h3409_0009);
        put_word(64,   32'h03E0_0008);
        put_word(68,   32'h3408_0008);
        restart();
        wait_wr("t5_jal",     5'd31, 32'h28, 32'h20);
        wait_wr("t5_jalslot", 5'd10, 32'hA,  32'h24);
        wait_wr("t5_jrslot",  5'd8,  32'h8,  32'h44);
        wait_wr("t5_return",  5'd9,  32'h9,  32'h28);

        // 6a: BREAK halts without error and freezes the flash address
        clear_flash();
        put_word(0, 32'h0000_000D);
        restart();
        wait_halt();
        chk("t6_brk_halted", {31'h0, halted}, 32'd1);
        chk("t6_brk_error",  {31'h0, error},  32'd0);
        chk("t6_brk_pc",     dbg_pc, 32'h0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fl_if.FL_ADDR !== 22'd3 || dbg_pc !== 32'h0) bad++;
        end
        chk("t6_brk_frozen", bad, 32'd0);

        // 6b: illegal opcode 0x3F
        put_word(0, 32'hFC00_0000);
        restart();
        wait_halt();
        chk("t6_ill_halted", {31'h0, halted}, 32'd1);
        chk("t6_ill_error",  {31'h0, error},  32'd1);

        // 6c: one reset cycle clears sticky flags, then reset mid-fetch restarts at 0
        clear_flash();
        put_word(0, 32'h3405_0005);
        put_word(4, 32'h3406_0006);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6_clr");
        rst = 1'b0;
        wait_wr("t6_first", 5'd5, 32'h5, 32'h0);
        repeat (4) @(negedge clk);
        chk("t6_midfetch_addr", {10'h0, fl_if.FL_ADDR}, 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6_mid");
        rst = 1'b0;
        wait_wr("t6_again", 5'd5, 32'h5, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
